mem_copy_master: RTL and testbench
==================================

# mem_copy_master

Bus initiator for the 8-bit single-port data memory of the single-cycle MIPS datapath. On a start pulse, it copies a block of bytes from a source address range to a destination range through the memory's MemRead/MemWrite port. It also accumulates an 8-bit modular checksum of the bytes moved. It is the master at the other end of the data-memory interface and is used for self-test and data staging when the core is not driving the port.

## Interface
- ADDR_W, 8, memory address width; addresses wrap modulo 2^ADDR_W
- DATA_W, 8, memory data width and checksum width
- clk  in  1  system clock; all state changes on posedge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request pulse; sampled only in IDLE
- src_addr  in  ADDR_W  first source byte address; latched on accepted start
- dst_addr  in  ADDR_W  first destination byte address; latched on accepted start
- length  in  8  byte count, 0..255; latched on accepted start
- busy  out  1  high in RD and WR states
- done  out  1  one-cycle pulse in DONE state
- checksum  out  DATA_W  sum of all bytes read, modulo 2^DATA_W
- Address  out  ADDR_W  memory address
- WriteData  out  DATA_W  memory write data
- MemWrite  out  1  memory write strobe; memory writes on the next posedge
- MemRead  out  1  memory read strobe; memory drives ReadData at the following negedge
- ReadData  in  DATA_W  memory read data; valid before the posedge that ends a MemRead cycle

## Operation
- States: IDLE, RD, WR, DONE. All outputs are registered.
- **IDLE**
  - start=1 latches src, dst and length, clears the index i and checksum.
  - If length=0, the next state is DONE. Otherwise the next state is RD.
  - start=0 stays in IDLE.
- **RD**
  - Drives Address=src+i (mod 2^ADDR_W), MemRead=1, MemWrite=0.
  - At the closing posedge, captures ReadData into the byte buffer, adds ReadData to checksum (mod 2^DATA_W), and moves to WR.
- **WR**
  - Drives Address=dst+i (mod 2^ADDR_W), WriteData=buffer, MemWrite=1, MemRead=0.
  - At the closing posedge, increments i. If i+1==length, the next state is DONE. Otherwise the next state is RD.
- **DONE**
  - done=1, busy=0, both strobes low.
  - Unconditionally returns to IDLE.
- Copying is strictly forward, one byte at a time.
  - Overlapping ranges with dst>src replicate data; this is defined behaviour, not an error.
  - src=dst rewrites the bytes unchanged.
- start is ignored in RD, WR and DONE.
  - A start held high through DONE is accepted in the following IDLE cycle.
- MemRead and MemWrite are never high in the same cycle.
  - In IDLE and DONE, both are low; Address and WriteData hold their last value.
- checksum holds its value after DONE until the next accepted start.

## Timing
- Reset values: state=IDLE, busy=0, done=0, MemRead=0, MemWrite=0, Address=0, WriteData=0, checksum=0, i=0.
- Reset asserted mid-transfer:
  - Strobes drop immediately (asynchronously).
  - The transfer is abandoned; destination bytes already written remain written.
- Cycle count, with E0 = the posedge that samples start:
  - Byte k is in RD during the cycle after E(2k) and in WR during the cycle after E(2k+1).
  - DONE (done=1) is in the cycle after E(2L). IDLE resumes after E(2L+1).
  - The cost is 2 cycles per byte plus 1 DONE cycle.
- length=0: DONE in the cycle after E0, with no memory strobes.
- length=255: 255 bytes, 510 busy cycles. Address wraps from 255 to 0 without stalls.
- Read capture: ReadData is sampled at the posedge ending RD. It relies on the memory updating ReadData on the preceding negedge.

## Test plan
- Memory preload 100:114, 101:6, 102:213, 103:14; start with src=100, dst=200, len=4.
  - Required: mem[200..203]=114,6,213,14.
  - Required: checksum=91 (347 mod 256).
  - Required: busy high for exactly 8 cycles; done pulses once in the cycle after E8.
- len=0 with src=10, dst=20.
  - Required: done in the cycle after E0, busy never high, no MemRead/MemWrite, checksum=0.
- Wrap-around: src=254, dst=1, len=3, with mem[254]=1, mem[255]=2, mem[0]=3.
  - Required: mem[1..3]=1,2,3 and checksum=6.
- Overlap: mem[50]=7, src=50, dst=51, len=3.
  - Required: mem[51..53]=7,7,7.
- Start pulses during busy, plus a strobe-exclusivity check:
  - Pulse start in RD and in WR, with different src, dst and len.
  - Required: ignored; the original transfer completes unchanged.
  - MemRead & MemWrite is never 1 in any cycle.
- Reset mid-transfer: assert rst during byte 2 of a len=4 copy.
  - Required: strobes low immediately, all outputs at reset values, and only bytes 0..1 written.
  - A new start after reset runs a full copy correctly.

Source files
------------

// File: rtl/mem_copy_master_if.sv
// Control and data-memory port bundle for mem_copy_master.
// The master modport is the copy engine; slave is the requester plus memory side.
interface mem_copy_master_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    // Request / status
    logic              start;
    logic [ADDR_W-1:0] src_addr;
    logic [ADDR_W-1:0] dst_addr;
    logic [7:0]        length;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] checksum;

    // Data-memory port
    logic [ADDR_W-1:0] Address;
    logic [DATA_W-1:0] WriteData;
    logic              MemWrite;
    logic              MemRead;
    logic [DATA_W-1:0] ReadData;

    modport master (
        input  start, src_addr, dst_addr, length, ReadData,
        output busy, done, checksum, Address, WriteData, MemWrite, MemRead
    );

    modport slave (
        output start, src_addr, dst_addr, length, ReadData,
        input  busy, done, checksum, Address, WriteData, MemWrite, MemRead
    );
endinterface

// File: rtl/mem_copy_master.sv
// Block-copy bus initiator for the single-port data memory: alternates one read
// and one write per byte, accumulating a modular checksum of the bytes read.
module mem_copy_master #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    mem_copy_master_if.master bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_DONE
    } state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] src_q;
    logic [ADDR_W-1:0] dst_q;
    logic [7:0]        len_q;
    logic [7:0]        idx_q;
    logic [DATA_W-1:0] csum_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;   // doubles as the byte buffer between RD and WR
    logic              mem_read_q;
    logic              mem_write_q;
    logic              busy_q;
    logic              done_q;

    logic [7:0]        idx_d;
    logic              last_d;
    logic [ADDR_W-1:0] next_rd_addr_d;
    logic [ADDR_W-1:0] wr_addr_d;
    logic [DATA_W-1:0] csum_d;

    // NOTE: every always_comb output gets a value on every path, so no latch
    // can be inferred; here the expressions are unconditional.
    always_comb begin
        idx_d          = idx_q + 8'd1;
        last_d         = (idx_d == len_q);
        next_rd_addr_d = src_q + ADDR_W'(idx_d);
        wr_addr_d      = dst_q + ADDR_W'(idx_q);
        csum_d         = csum_q + bus.ReadData;
    end

    // NOTE: all state is updated with non-blocking assignments so every
    // register samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            src_q       <= '0;
            dst_q       <= '0;
            len_q       <= '0;
            idx_q       <= '0;
            csum_q      <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        src_q  <= bus.src_addr;
                        dst_q  <= bus.dst_addr;
                        len_q  <= bus.length;
                        idx_q  <= '0;
                        csum_q <= '0;
                        if (bus.length == 8'd0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q    <= S_RD;
                            addr_q     <= bus.src_addr;
                            mem_read_q <= 1'b1;
                            busy_q     <= 1'b1;
                        end
                    end
                end

                S_RD: begin
                    // ReadData was driven by the memory on the preceding negedge.
                    wdata_q     <= bus.ReadData;
                    csum_q      <= csum_d;
                    addr_q      <= wr_addr_d;
                    mem_read_q  <= 1'b0;
                    mem_write_q <= 1'b1;
                    state_q     <= S_WR;
                end

                S_WR: begin
                    idx_q       <= idx_d;
                    mem_write_q <= 1'b0;
                    if (last_d) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        state_q    <= S_RD;
                        addr_q     <= next_rd_addr_d;
                        mem_read_q <= 1'b1;
                    end
                end

                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end

                default: begin
                    state_q     <= S_IDLE;
                    mem_read_q  <= 1'b0;
                    mem_write_q <= 1'b0;
                    busy_q      <= 1'b0;
                    done_q      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.checksum  = csum_q;
    assign bus.Address   = addr_q;
    assign bus.WriteData = wdata_q;
    assign bus.MemRead   = mem_read_q;
    assign bus.MemWrite  = mem_write_q;

endmodule

// File: tb/tb_mem_copy_master.sv
// Directed bench for mem_copy_master: behavioural 256-byte memory, strobe
// monitor and hand-computed expectations for each copy scenario.
module tb_mem_copy_master;

    logic clk;
    logic rst;

    mem_copy_master_if #(.ADDR_W(8), .DATA_W(8)) bus ();

    mem_copy_master #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural data memory; preload goes through the same process.
    logic [7:0] mem [256];
    logic       pl_en;
    logic [7:0] pl_addr;
    logic [7:0] pl_data;

    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (bus.MemWrite) mem[bus.Address] <= bus.WriteData;
    end

    always @(negedge clk) begin
        if (bus.MemRead) bus.ReadData <= mem[bus.Address];
    end

    // Cumulative activity counters sampled mid-cycle.
    int busy_cnt = 0;
    int done_cnt = 0;
    int rd_cnt   = 0;
    int wr_cnt   = 0;
    int both_cnt = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.busy) busy_cnt <= busy_cnt + 1;
            if (bus.done) done_cnt <= done_cnt + 1;
            if (bus.MemRead) rd_cnt <= rd_cnt + 1;
            if (bus.MemWrite) wr_cnt <= wr_cnt + 1;
            if (bus.MemRead && bus.MemWrite) both_cnt <= both_cnt + 1;
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        pl_en   = 1'b1;
        pl_addr = a;
        pl_data = d;
        @(negedge clk);
        pl_en   = 1'b0;
    endtask

    int b_busy, b_done, b_rd, b_wr;

    task automatic snap();
        b_busy = busy_cnt;
        b_done = done_cnt;
        b_rd   = rd_cnt;
        b_wr   = wr_cnt;
    endtask

    // Starts a copy; done_at = index n of the cycle after E(n) where done is
    // seen (-1 on timeout, -2 when stopped early at stop_at).
    task automatic run_copy(input logic [7:0] src, input logic [7:0] dst,
                            input logic [7:0] len, input bit glitch,
                            input int stop_at, output int done_at);
        int n;
        @(negedge clk);
        bus.start    = 1'b1;
        bus.src_addr = src;
        bus.dst_addr = dst;
        bus.length   = len;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        n = 0;
        done_at = -1;
        while (n < 600) begin
            if (bus.done) begin
                done_at = n;
                break;
            end
            if (n == stop_at) begin
                done_at = -2;
                break;
            end
            if (glitch && n < 2) begin
                bus.start    = 1'b1;
                bus.src_addr = 8'd100 + 8'(n);
                bus.dst_addr = 8'd150;
                bus.length   = 8'd9;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        bus.start = 1'b0;
        #1;
    endtask

    int d;

    initial begin
        rst          = 1'b1;
        pl_en        = 1'b0;
        pl_addr      = '0;
        pl_data      = '0;
        bus.start    = 1'b0;
        bus.src_addr = '0;
        bus.dst_addr = '0;
        bus.length   = '0;
        bus.ReadData = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;

        check("rst_busy", 32'(bus.busy), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_memread", 32'(bus.MemRead), 0);
        check("rst_memwrite", 32'(bus.MemWrite), 0);
        check("rst_address", 32'(bus.Address), 0);
        check("rst_writedata", 32'(bus.WriteData), 0);
        check("rst_checksum", 32'(bus.checksum), 0);

        // Basic 4-byte copy
        preload(8'd100, 8'd114);
        preload(8'd101, 8'd6);
        preload(8'd102, 8'd213);
        preload(8'd103, 8'd14);
        snap();
        run_copy(8'd100, 8'd200, 8'd4, 1'b0, -1, d);
        check("basic_done_cycle", 32'(d), 8);
        check("basic_busy_cycles", 32'(busy_cnt - b_busy), 8);
        check("basic_done_pulses", 32'(done_cnt - b_done), 1);
        check("basic_reads", 32'(rd_cnt - b_rd), 4);
        check("basic_writes", 32'(wr_cnt - b_wr), 4);
        check("basic_mem200", 32'(mem[200]), 114);
        check("basic_mem201", 32'(mem[201]), 6);
        check("basic_mem202", 32'(mem[202]), 213);
        check("basic_mem203", 32'(mem[203]), 14);
        check("basic_checksum", 32'(bus.checksum), 91);
        repeat (3) @(negedge clk);
        check("basic_checksum_hold", 32'(bus.checksum), 91);
        check("basic_done_single", 32'(done_cnt - b_done), 1);

        // Zero length
        snap();
        run_copy(8'd10, 8'd20, 8'd0, 1'b0, -1, d);
        check("len0_done_cycle", 32'(d), 0);
        check("len0_busy", 32'(busy_cnt - b_busy), 0);
        check("len0_reads", 32'(rd_cnt - b_rd), 0);
        check("len0_writes", 32'(wr_cnt - b_wr), 0);
        check("len0_checksum", 32'(bus.checksum), 0);

        // Address wrap-around
        preload(8'd254, 8'd1);
        preload(8'd255, 8'd2);
        preload(8'd0, 8'd3);
        run_copy(8'd254, 8'd1, 8'd3, 1'b0, -1, d);
        check("wrap_done_cycle", 32'(d), 6);
        check("wrap_mem1", 32'(mem[1]), 1);
        check("wrap_mem2", 32'(mem[2]), 2);
        check("wrap_mem3", 32'(mem[3]), 3);
        check("wrap_checksum", 32'(bus.checksum), 6);

        // Forward overlap replicates the first byte
        preload(8'd50, 8'd7);
        preload(8'd51, 8'd17);
        preload(8'd52, 8'd34);
        preload(8'd53, 8'd51);
        run_copy(8'd50, 8'd51, 8'd3, 1'b0, -1, d);
        check("ovl_mem51", 32'(mem[51]), 7);
        check("ovl_mem52", 32'(mem[52]), 7);
        check("ovl_mem53", 32'(mem[53]), 7);
        check("ovl_checksum", 32'(bus.checksum), 21);

        // start pulses during RD and WR must be ignored
        preload(8'd60, 8'd9);
        preload(8'd61, 8'd8);
        preload(8'd62, 8'd5);
        preload(8'd150, 8'hAA);
        snap();
        run_copy(8'd60, 8'd70, 8'd3, 1'b1, -1, d);
        check("glitch_done_cycle", 32'(d), 6);
        check("glitch_busy_cycles", 32'(busy_cnt - b_busy), 6);
        check("glitch_mem70", 32'(mem[70]), 9);
        check("glitch_mem71", 32'(mem[71]), 8);
        check("glitch_mem72", 32'(mem[72]), 5);
        check("glitch_mem150", 32'(mem[150]), 8'hAA);
        check("glitch_checksum", 32'(bus.checksum), 22);
        repeat (3) @(negedge clk);
        check("glitch_no_restart", 32'(bus.busy), 0);

        // Reset during the write of byte 2
        preload(8'd80, 8'd1);
        preload(8'd81, 8'd2);
        preload(8'd82, 8'd3);
        preload(8'd83, 8'd4);
        for (int k = 0; k < 4; k++) preload(8'd90 + 8'(k), 8'hEE);
        run_copy(8'd80, 8'd90, 8'd4, 1'b0, 5, d);
        check("rstmid_reached", 32'(d), 32'hFFFF_FFFE);
        check("rstmid_in_wr", 32'(bus.MemWrite), 1);
        #1;
        rst = 1'b1;
        #1;
        check("rstmid_memwrite", 32'(bus.MemWrite), 0);
        check("rstmid_memread", 32'(bus.MemRead), 0);
        check("rstmid_busy", 32'(bus.busy), 0);
        check("rstmid_done", 32'(bus.done), 0);
        check("rstmid_address", 32'(bus.Address), 0);
        check("rstmid_writedata", 32'(bus.WriteData), 0);
        check("rstmid_checksum", 32'(bus.checksum), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rstmid_mem90", 32'(mem[90]), 1);
        check("rstmid_mem91", 32'(mem[91]), 2);
        check("rstmid_mem92", 32'(mem[92]), 8'hEE);
        check("rstmid_mem93", 32'(mem[93]), 8'hEE);

        run_copy(8'd80, 8'd90, 8'd4, 1'b0, -1, d);
        check("after_rst_done_cycle", 32'(d), 8);
        check("after_rst_mem92", 32'(mem[92]), 3);
        check("after_rst_mem93", 32'(mem[93]), 4);
        check("after_rst_checksum", 32'(bus.checksum), 10);

        @(negedge clk);
        check("strobe_exclusive", 32'(both_cnt), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
